// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state encoding
// and the default operand width.
`timescale 1ns/1ps
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder; the shared datapath cell that the
// controller steps through one operand bit per clock.
`timescale 1ns/1ps
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts {a,b,ci}, runs the full-adder cell
// LSB-first for WIDTH clocks, then presents {co,sum} until the consumer takes it.
`timescale 1ns/1ps
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE; out_valid is high only in DONE and
    // stays high, with sum/co frozen, until the edge where out_ready is seen.

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;

    serial_fa_cell u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .ci  (carry),
        .sum (fa_s),
        .co  (fa_co)
    );

    // New sum bits enter at the MSB so that after WIDTH shifts bit 0 is the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_sh_nxt = fa_s;
        end else begin : g_wn
            assign sum_sh_nxt = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            co        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= ci;
                        cnt      <= '0;
                        sum_sh   <= '0;
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_sh <= sum_sh_nxt;
                    carry  <= fa_co;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (cnt == CNT_LAST) begin
                        // Counter holds at the terminal value instead of wrapping.
                        state     <= ST_DONE;
                        sum       <= sum_sh_nxt;
                        co        <= fa_co;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Sequences a single 1-bit full-adder cell LSB-first, one bit per clock, holding the running carry in a register.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits between a requester and the shared full-adder datapath in area-constrained arithmetic paths.

Parameters:
- WIDTH, 8, operand/sum width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH) with minimum 1, bit-counter width (derived; not overridden).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  requester presents operands.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A; sampled only on accept.
- b  in  WIDTH  operand B; sampled only on accept.
- ci  in  1  carry-in; sampled only on accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result sum; stable while out_valid is high.
- co  out  1  result carry-out; stable while out_valid is high.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, co=0, counter=0, operand and carry registers=0. Reset mid-RUN or mid-DONE aborts immediately and discards the result.
- States: IDLE, RUN, DONE. Encoding is one-hot or binary (implementer's choice, shared constants).
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load a_sh<=a, b_sh<=b, carry<=ci, cnt<=0, clear the sum shift register, go to RUN.
- RUN:
  - in_ready=0; in_valid, a, b and ci are ignored.
  - Each edge: full-adder cell inputs are a_sh[0], b_sh[0], carry.
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}; carry <= cell co; a_sh and b_sh shift right by one; cnt <= cnt+1.
  - When cnt==WIDTH-1 on an edge: go to DONE.
- DONE:
  - out_valid=1; sum=sum_sh; co=carry.
  - On an edge with out_ready=1: go to IDLE.
  - No same-cycle accept: in_ready stays 0 in DONE.
- Latency:
  - Accept edge at k; RUN occupies edges k+1 .. k+WIDTH; out_valid is high from edge k+WIDTH.
  - Minimum throughput is one operation per WIDTH+2 cycles.
- Output holding:
  - sum and co are registered outputs. They hold their last value in IDLE and are updated only on the RUN→DONE transition.
  - They must not toggle while out_valid=1.
- Backpressure: DONE holds indefinitely while out_ready=0. out_valid must not drop until the handshake completes.
- Arithmetic: {co,sum} = a + b + ci, exact over WIDTH+1 bits. Wrap of the sum into co is natural, with no saturation.
- Boundary cases:
  - WIDTH=1: RUN lasts exactly one cycle.
  - Counter terminal compare is on WIDTH-1 and never wraps.
  - out_ready high outside DONE has no effect.
  - in_valid held high continuously: the next operation is accepted on the first IDLE edge.

Decomposition:
- Shared package/header serial_adder_pkg:
  - State encoding constants (ST_IDLE, ST_RUN, ST_DONE).
  - Default WIDTH.
- One sub-module, serial_fa_cell:
  - Purely combinational 1-bit full adder with ports a, b, ci, sum, co.
  - Instantiated once; the controller holds all sequential state.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, ci=0, out_ready=1 → out_valid rises exactly 8 edges after accept; sum=0x10, co=0; back to IDLE with in_ready=1 one edge later.
- WIDTH=8, a=0xFF, b=0x00, ci=1 → sum=0x00, co=1. Then a=0xFF, b=0xFF, ci=1 back-to-back (in_valid held) → sum=0xFF, co=1, accepted on the first IDLE edge.
- Backpressure: a=0x55, b=0xAA, ci=0, out_ready=0 for 5 cycles after out_valid → out_valid, sum=0xFF and co=0 stay stable; in_ready=0 throughout; completes on the first out_ready=1 edge.
- Operand change during RUN: accept a=0x03, b=0x04, then drive a=0xFF, b=0xFF, in_valid=1 mid-RUN → result unaffected (sum=0x07, co=0); new request accepted only after DONE→IDLE.
- Reset mid-RUN: assert rst asynchronously (between edges) after 3 RUN cycles → immediate out_valid=0, busy=0, in_ready=1, sum=0, co=0; a new operation afterwards computes correctly.
- WIDTH=1 instance: exhaustive 8 combinations of a, b, ci → {co,sum} matches the full-adder truth table, each with out_valid 1 edge after accept.
